conv_output_arbiter: RTL

- Round-robin scheduler that shares one downstream word-serial path among NUM_KERNELS parallel conv_layer kernels.
- Grants one kernel at a time and streams its LAYER_HEIGHT-word output vector one word per accepted handshake, tagged with kernel and word index.
- Returns yumi to the granted kernel after its last word is accepted.
- Pulses frame_done_o once every kernel has been drained for the current frame.

---
 rtl/conv_output_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/conv_output_arbiter.sv
// Round-robin arbiter that streams one kernel's LAYER_HEIGHT-word vector at a time
// onto a shared word-serial output, with per-frame masking of already-served kernels.
`timescale 1ns/1ps
module conv_output_arbiter #(
  parameter int NUM_KERNELS  = 8,
  parameter int LAYER_HEIGHT = 13,
  parameter int WORD_SIZE    = 16
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic [NUM_KERNELS-1:0]                        valid_i,
  input  logic [NUM_KERNELS*LAYER_HEIGHT*WORD_SIZE-1:0] data_i,
  output logic [NUM_KERNELS-1:0]                        yumi_o,
  output logic [WORD_SIZE-1:0]                          data_o,
  output logic [$clog2(NUM_KERNELS)-1:0]                kernel_o,
  output logic [$clog2(LAYER_HEIGHT)-1:0]               index_o,
  output logic                                          last_o,
  output logic                                          valid_o,
  input  logic                                          yumi_i,
  output logic                                          frame_done_o
);

  localparam int KW = $clog2(NUM_KERNELS);
  localparam int IW = $clog2(LAYER_HEIGHT);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [KW-1:0]          grant_q, grant_d;
  logic [KW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_KERNELS-1:0] served_q, served_d;
  logic [IW-1:0]          word_cnt_q, word_cnt_d;
  logic                   frame_done_q, frame_done_d;

  logic [NUM_KERNELS-1:0] req, grant_oh, served_next;
  logic [KW-1:0]          pick;
  logic                   found;
  logic                   streaming, last, accept_last;

  assign req         = valid_i & ~served_q;
  assign streaming   = (state_q == S_STREAM);
  assign last        = (word_cnt_q == IW'(LAYER_HEIGHT - 1));
  assign accept_last = streaming & yumi_i & last;
  assign grant_oh    = NUM_KERNELS'(1) << grant_q;
  assign served_next = served_q | grant_oh;

  // First requesting kernel at or above rr_ptr, wrapping around to 0.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_KERNELS;
      if (!found && req[idx]) begin
        pick  = KW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    served_d     = served_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = pick;
          word_cnt_d = '0;
          state_d    = S_STREAM;
        end
      end
      default: begin
        if (yumi_i) begin
          if (last) begin
            rr_ptr_d = KW'((int'(grant_q) + 1) % NUM_KERNELS);
            state_d  = S_IDLE;
            // Completing the frame re-opens every kernel for the next one.
            if (&served_next) begin
              served_d     = '0;
              frame_done_d = 1'b1;
            end else begin
              served_d = served_next;
            end
          end else begin
            word_cnt_d = word_cnt_q + IW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      served_q     <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      served_q     <= served_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign valid_o      = streaming;
  assign last_o       = streaming & last;
  assign kernel_o     = streaming ? grant_q : '0;
  assign index_o      = streaming ? word_cnt_q : '0;
  assign data_o       = streaming ?
                        data_i[(int'(grant_q) * LAYER_HEIGHT + int'(word_cnt_q)) * WORD_SIZE +: WORD_SIZE] :
                        '0;
  assign yumi_o       = accept_last ? grant_oh : '0;
  assign frame_done_o = frame_done_q;

endmodule
